gate_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the two-input basic-gates unit (AND, NAND, OR, NOR, NOT_a, XOR, XNOR). On a start pulse it drives the unit's `a`/`b` inputs through all four combinations, waits a programmable settle time, and samples the seven gate outputs. It compares each sample against expected values and accumulates a pass/fail summary. It sits beside the gates unit at top level, owning its inputs and observing its outputs.

---
 rtl/gate_bist_pkg.sv | 39 +++
 rtl/gate_bist_ctrl_if.sv | 31 +++
 rtl/gate_bist_ctrl.sv | 133 +++++++++++++
 tb/tb_gate_bist_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gates-unit BIST sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Bit positions of each gate output within gate_y
  localparam int Y_AND  = 0;
  localparam int Y_NAND = 1;
  localparam int Y_OR   = 2;
  localparam int Y_NOR  = 3;
  localparam int Y_NOTA = 4;
  localparam int Y_XOR  = 5;
  localparam int Y_XNOR = 6;

  localparam int NUM_VEC = 4;
  localparam int Y_W     = 7;

  // What a healthy gates unit produces for inputs a, b
  function automatic logic [Y_W-1:0] gate_expect(input logic a, input logic b);
    logic [Y_W-1:0] y;
    y         = '0;
    y[Y_AND]  = a & b;
    y[Y_NAND] = ~(a & b);
    y[Y_OR]   = a | b;
    y[Y_NOR]  = ~(a | b);
    y[Y_NOTA] = ~a;
    y[Y_XOR]  = a ^ b;
    y[Y_XNOR] = ~(a ^ b);
    return y;
  endfunction

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Signal bundle between the BIST sequencer and its environment (host + gates unit).
// Latency: n/a (wiring only).
// Backpressure: none; start/abort are level requests sampled by the sequencer.
interface gate_bist_ctrl_if;
  import gate_bist_pkg::*;

  logic               start;
  logic               abort;
  logic               gate_a;
  logic               gate_b;
  logic [Y_W-1:0]     gate_y;
  logic               busy;
  logic               done;
  logic               pass;
  logic [NUM_VEC-1:0] fail_vec;
  logic [Y_W-1:0]     fail_bits;
  logic [7:0]         err_count;

  // Environment side: issues requests, closes the loop through the gates unit
  modport master (
    output start, abort, gate_y,
    input  gate_a, gate_b, busy, done, pass, fail_vec, fail_bits, err_count
  );

  // Sequencer side
  modport slave (
    input  start, abort, gate_y,
    output gate_a, gate_b, busy, done, pass, fail_vec, fail_bits, err_count
  );

endinterface

// File: rtl/gate_bist_ctrl.sv
// Sweeps gates-unit inputs through 00,01,10,11, samples after a settle time, accumulates mismatches.
// Latency: 4*LOOPS*(SETTLE_CYCLES+1) cycles from accepted start to done; all outputs registered.
// Backpressure: start ignored while busy; abort cancels a run in SETTLE/CHECK without a done pulse.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1
) (
  input logic             clk,
  input logic             rst_n,
  gate_bist_ctrl_if.slave bus
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_LOOP   = 8'(LOOPS - 1);

  state_t             state, state_nxt;
  logic [7:0]         settle_cnt;
  logic [7:0]         loop_cnt;
  logic [1:0]         vec;        // {a,b} currently driven
  logic               busy_q, done_q, pass_q;
  logic [NUM_VEC-1:0] fail_vec_q;
  logic [Y_W-1:0]     fail_bits_q;
  logic [7:0]         err_q;

  logic               run_start, run_abort, do_check, last_vec;
  logic [Y_W-1:0]     mis;

  assign bus.gate_a    = vec[1];
  assign bus.gate_b    = vec[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_vec  = fail_vec_q;
  assign bus.fail_bits = fail_bits_q;
  assign bus.err_count = err_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus the per-cycle control strobes for the datapath
  always_comb begin
    state_nxt = state;
    run_start = 1'b0;
    run_abort = 1'b0;
    do_check  = 1'b0;
    mis       = bus.gate_y ^ gate_expect(vec[1], vec[0]);
    last_vec  = (vec == 2'd3) && (loop_cnt == LAST_LOOP);
    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nxt = ST_SETTLE;
          run_start = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          state_nxt = ST_IDLE;
          run_abort = 1'b1;
        end else if (settle_cnt == 8'd0) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bus.abort) begin
          state_nxt = ST_IDLE;
          run_abort = 1'b1;
        end else begin
          do_check  = 1'b1;
          state_nxt = last_vec ? ST_DONE : ST_SETTLE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Vector stepping, settle/loop counting and result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt  <= '0;
      loop_cnt    <= '0;
      vec         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_vec_q  <= '0;
      fail_bits_q <= '0;
      err_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if (run_start) begin
        settle_cnt  <= SETTLE_LOAD;
        loop_cnt    <= '0;
        vec         <= '0;
        busy_q      <= 1'b1;
        pass_q      <= 1'b0;
        fail_vec_q  <= '0;
        fail_bits_q <= '0;
        err_q       <= '0;
      end else if (run_abort) begin
        // partial sticky results are kept for post-mortem
        busy_q <= 1'b0;
        vec    <= '0;
        pass_q <= 1'b0;
      end else if (do_check) begin
        if (mis != '0) begin
          fail_bits_q     <= fail_bits_q | mis;
          fail_vec_q[vec] <= 1'b1;
          if (err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
        if (last_vec) begin
          done_q <= 1'b1;
          pass_q <= (fail_vec_q == '0) && (mis == '0);
        end else begin
          vec        <= vec + 2'd1;
          settle_cnt <= SETTLE_LOAD;
          if (vec == 2'd3) loop_cnt <= loop_cnt + 8'd1;
        end
      end else if (state == ST_SETTLE) begin
        if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
      end else if (state == ST_DONE) begin
        busy_q <= 1'b0;
        vec    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: three instances (defaults, LOOPS=3, LOOPS=70/SETTLE=1) with faulty gate models.
// Latency: n/a.
// Backpressure: n/a.
module tb_gate_bist_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic       a;
    logic       b;
    logic [3:0] fv;
    logic [6:0] fb;
    logic [7:0] ec;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_r [3];
  logic abort_r [3];
  int   fm [3];          // 0 good, 1 XOR forced 0, 2 NAND stuck 1, 3 all outputs inverted

  int   S_P [3] = '{2, 2, 1};
  int   L_P [3] = '{1, 3, 70};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gate_bist_ctrl_if bus0 ();
  gate_bist_ctrl_if bus1 ();
  gate_bist_ctrl_if bus2 ();

  gate_bist_ctrl #(.SETTLE_CYCLES(2), .LOOPS(1))  u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  gate_bist_ctrl #(.SETTLE_CYCLES(2), .LOOPS(3))  u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  gate_bist_ctrl #(.SETTLE_CYCLES(1), .LOOPS(70)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Gates unit under test, with selectable fault
  function automatic logic [6:0] gates(input logic a, input logic b, input int f);
    logic [6:0] y;
    y = {~(a ^ b), a ^ b, ~a, ~(a | b), a | b, ~(a & b), a & b};
    case (f)
      1:       y[5] = 1'b0;
      2:       y[1] = 1'b1;
      3:       y = ~y;
      default: ;
    endcase
    return y;
  endfunction

  assign bus0.start = start_r[0];
  assign bus1.start = start_r[1];
  assign bus2.start = start_r[2];
  assign bus0.abort = abort_r[0];
  assign bus1.abort = abort_r[1];
  assign bus2.abort = abort_r[2];
  always_comb bus0.gate_y = gates(bus0.gate_a, bus0.gate_b, fm[0]);
  always_comb bus1.gate_y = gates(bus1.gate_a, bus1.gate_b, fm[1]);
  always_comb bus2.gate_y = gates(bus2.gate_a, bus2.gate_b, fm[2]);

  obs_t obs [3];
  assign obs[0] = {bus0.busy, bus0.done, bus0.pass, bus0.gate_a, bus0.gate_b,
                   bus0.fail_vec, bus0.fail_bits, bus0.err_count};
  assign obs[1] = {bus1.busy, bus1.done, bus1.pass, bus1.gate_a, bus1.gate_b,
                   bus1.fail_vec, bus1.fail_bits, bus1.err_count};
  assign obs[2] = {bus2.busy, bus2.done, bus2.pass, bus2.gate_a, bus2.gate_b,
                   bus2.fail_vec, bus2.fail_bits, bus2.err_count};

  task automatic check(input string nm, input int inst, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[u%0d] @%0t: got %0d, want %0d", nm, inst, $time, act, exp);
    end
  endtask

  // Reference model: a run is a count k of edges since the accepted start; samples fall
  // on every (S+1)-th edge, sample j covering vector (j-1)%4.
  bit       m_run  [3];
  int       m_k    [3];
  bit [3:0] m_fv   [3];
  bit [6:0] m_fb   [3];
  int       m_ec   [3];
  bit       m_pass [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_run[i] = 0; m_k[i] = 0; m_fv[i] = 0; m_fb[i] = 0; m_ec[i] = 0; m_pass[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int n, v;
        bit [6:0] mm;
        n = 4 * L_P[i] * (S_P[i] + 1);
        if (!m_run[i]) begin
          if (start_r[i] && !abort_r[i]) begin
            m_run[i] = 1; m_k[i] = 0; m_fv[i] = 0; m_fb[i] = 0; m_ec[i] = 0; m_pass[i] = 0;
          end
        end else if (m_k[i] == n) begin
          m_run[i] = 0;
        end else if (abort_r[i]) begin
          m_run[i]  = 0;
          m_pass[i] = 0;
        end else begin
          m_k[i]++;
          if (m_k[i] % (S_P[i] + 1) == 0) begin
            v  = (m_k[i] / (S_P[i] + 1) - 1) % 4;
            mm = gates(logic'(v / 2), logic'(v % 2), fm[i]) ^ gates(logic'(v / 2), logic'(v % 2), 0);
            if (mm != 0) begin
              m_fv[i] = m_fv[i] | (4'b0001 << v);
              m_fb[i] = m_fb[i] | mm;
              m_ec[i] = (m_ec[i] < 255) ? m_ec[i] + 1 : 255;
            end
          end
          if (m_k[i] == n) m_pass[i] = (m_fv[i] == 0);
        end
      end
    end
  end

  function automatic obs_t model_exp(input int i);
    obs_t e;
    int   n, v;
    n      = 4 * L_P[i] * (S_P[i] + 1);
    v      = !m_run[i] ? 0 : (m_k[i] == n) ? 3 : (m_k[i] / (S_P[i] + 1)) % 4;
    e.busy = m_run[i];
    e.done = m_run[i] && (m_k[i] == n);
    e.pass = m_pass[i];
    e.a    = logic'(v / 2);
    e.b    = logic'(v % 2);
    e.fv   = m_fv[i];
    e.fb   = m_fb[i];
    e.ec   = 8'(m_ec[i]);
    return e;
  endfunction

  // Cycle-by-cycle comparison of every instance against the model
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      obs_t e;
      obs_t a;
      e = model_exp(i);
      a = obs[i];
      check("busy", i, a.busy, e.busy);
      check("done", i, a.done, e.done);
      check("pass", i, a.pass, e.pass);
      check("gate_a", i, a.a, e.a);
      check("gate_b", i, a.b, e.b);
      check("fail_vec", i, a.fv, e.fv);
      check("fail_bits", i, a.fb, e.fb);
      check("err_count", i, a.ec, e.ec);
    end
  end

  initial begin
    int d0, d1, d2, d, nd;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin start_r[i] = 1'b0; abort_r[i] = 1'b0; end
    fm[0] = 0; fm[1] = 2; fm[2] = 3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 0, bus0.busy, 0);
    check("rst_gates", 0, {bus0.gate_a, bus0.gate_b}, 0);
    check("rst_err", 2, bus2.err_count, 0);
    check("rst_pass", 1, bus1.pass, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All three instances start together
    for (int i = 0; i < 3; i++) start_r[i] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) start_r[i] = 1'b0;
    check("busy_at_E0", 0, bus0.busy, 1);
    d0 = -1; d1 = -1; d2 = -1;
    for (int c = 1; c <= 600; c++) begin
      @(posedge clk); #1;
      if (c == 4) check("vec1_ab", 0, {bus0.gate_a, bus0.gate_b}, 1);
      if (c == 9) check("vec3_ab", 0, {bus0.gate_a, bus0.gate_b}, 3);
      if (bus0.done && d0 < 0) d0 = c;
      if (bus1.done && d1 < 0) d1 = c;
      if (bus2.done && d2 < 0) d2 = c;
    end
    check("done_edge", 0, d0, 12);
    check("done_edge", 1, d1, 36);
    check("done_edge", 2, d2, 560);
    check("good_pass", 0, bus0.pass, 1);
    check("good_fv", 0, bus0.fail_vec, 0);
    check("good_ec", 0, bus0.err_count, 0);
    check("nand_fv", 1, bus1.fail_vec, 4'b1000);
    check("nand_fb", 1, bus1.fail_bits, 7'b0000010);
    check("nand_ec", 1, bus1.err_count, 3);
    check("inv_ec", 2, bus2.err_count, 255);
    check("inv_fv", 2, bus2.fail_vec, 4'hF);
    check("inv_fb", 2, bus2.fail_bits, 7'h7F);

    // XOR stuck low, start held high through the whole run and into IDLE
    fm[0] = 1;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    d = -1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (bus0.done) begin d = c; break; end
    end
    check("xor_done_edge", 0, d, 12);
    check("xor_fv", 0, bus0.fail_vec, 4'b0110);
    check("xor_fb", 0, bus0.fail_bits, 7'b0100000);
    check("xor_ec", 0, bus0.err_count, 2);
    check("xor_pass", 0, bus0.pass, 0);
    @(posedge clk); #1;
    check("held_start_idle", 0, bus0.busy, 0);
    @(posedge clk); #1;
    check("held_start_restart", 0, bus0.busy, 1);
    check("restart_clears_ec", 0, bus0.err_count, 0);
    start_r[0] = 1'b0;

    // Abort while vector 2 is settling
    repeat (6) @(posedge clk);
    #1;
    check("vec2_ab", 0, {bus0.gate_a, bus0.gate_b}, 2);
    abort_r[0] = 1'b1;
    @(posedge clk); #1;
    abort_r[0] = 1'b0;
    check("abort_busy", 0, bus0.busy, 0);
    check("abort_gates", 0, {bus0.gate_a, bus0.gate_b}, 0);
    check("abort_partial_fv", 0, bus0.fail_vec, 4'b0010);
    check("abort_partial_ec", 0, bus0.err_count, 1);
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus0.done) nd++;
    end
    check("abort_no_done", 0, nd, 0);

    // Clean rerun after abort
    fm[0] = 0;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    d = -1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (bus0.done) begin d = c; break; end
    end
    check("rerun_done_edge", 0, d, 12);
    check("rerun_pass", 0, bus0.pass, 1);
    check("rerun_fv", 0, bus0.fail_vec, 0);

    // start and abort together in IDLE
    repeat (2) @(posedge clk);
    #1;
    start_r[0] = 1'b1; abort_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0; abort_r[0] = 1'b0;
    check("start_abort_idle", 0, bus0.busy, 0);
    @(posedge clk); #1;
    check("start_abort_idle2", 0, bus0.busy, 0);

    // Asynchronous reset in the middle of SETTLE
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", 0, bus0.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 0, bus0.busy, 0);
    check("arst_gates", 0, {bus0.gate_a, bus0.gate_b}, 0);
    check("arst_fv", 1, bus1.fail_vec, 0);
    check("arst_ec", 2, bus2.err_count, 0);
    check("arst_fb", 2, bus2.fail_bits, 0);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 0, bus0.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
